mod_issue_ctrl: RTL

Upstream issue/response controller for the multi-cycle modulo unit (controller + datapath pair with start/done).
- Accepts operand pairs over a valid/ready request channel and holds them stable for the whole operation.
- Pulses the unit's start, then waits for done and captures the result.
- Presents the result on a valid/ready response channel.
- Short-circuits modulo-by-zero and, optionally, times out a hung unit.

---
 rtl/mod_issue_pkg.sv | 18 +
 rtl/mod_issue_ctrl_if.sv | 28 ++
 rtl/mod_issue_timer.sv | 37 +++
 rtl/mod_issue_ctrl.sv | 116 +++++++++++
 4 files changed

// File: rtl/mod_issue_pkg.sv
// Shared types and constants for the modulo-unit issue controller.
package mod_issue_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Counter must be able to hold the value TimeoutCycles itself.
  function automatic int unsigned timer_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mod_issue_ctrl_if.sv
// Request / unit / response bundle between the issue controller and its neighbours.
interface mod_issue_ctrl_if #(
  parameter int unsigned WIDTH = mod_issue_pkg::DefaultWidth
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             unit_start;
  logic [WIDTH-1:0] unit_a;
  logic [WIDTH-1:0] unit_b;
  logic [WIDTH-1:0] unit_result;
  logic             unit_done;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_err;

  modport master (
    input  req_valid, req_a, req_b, unit_result, unit_done, rsp_ready,
    output req_ready, unit_start, unit_a, unit_b, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    output req_valid, req_a, req_b, unit_result, unit_done, rsp_ready,
    input  req_ready, unit_start, unit_a, unit_b, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/mod_issue_timer.sv
// WAIT-state watchdog counter; only built when MOD_ISSUE_TIMEOUT_EN is defined.
module mod_issue_timer
  import mod_issue_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);
  localparam int unsigned CntW = timer_width(TimeoutCycles);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Fires on the WAIT cycle whose increment brings the count to TimeoutCycles.
  assign expired_o = inc_i && (cnt_q == CntW'(TimeoutCycles - 1));

endmodule

// File: rtl/mod_issue_ctrl.sv
// Issue/response controller for the multi-cycle modulo unit.
// Optional WAIT-state timeout is enabled by defining MOD_ISSUE_TIMEOUT_EN.
module mod_issue_ctrl
  import mod_issue_pkg::*;
#(
  parameter int unsigned WIDTH          = DefaultWidth,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                clk,
  input logic                reset,
  mod_issue_ctrl_if.master   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic             err_q, err_d, start_q, start_d, armed_q, armed_d;
  logic             accept, b_zero, done_hit, timeout_hit;

  assign accept   = (state_q == StIdle) && bus.req_valid;
  assign b_zero   = (bus.req_b == '0);
  // armed_q is low in the first WAIT cycle so a stale level-high done is ignored.
  assign done_hit = (state_q == StWait) && armed_q && bus.unit_done;

`ifdef MOD_ISSUE_TIMEOUT_EN
  logic expired;

  mod_issue_timer #(
    .TimeoutCycles(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clear_i  (state_q == StIssue),
    .inc_i    (state_q == StWait),
    .expired_o(expired)
  );

  assign timeout_hit = expired && !done_hit;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      start_q  <= start_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = b_zero ? StResp : StIssue;
      StIssue: state_d = StWait;
      StWait:  if (done_hit || timeout_hit) state_d = StResp;
      StResp:  if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    start_d  = 1'b0;
    armed_d  = (state_q == StWait);
    if (accept) begin
      a_d     = bus.req_a;
      b_d     = bus.req_b;
      start_d = !b_zero;
      if (b_zero) begin
        result_d = bus.req_a;
        err_d    = 1'b1;
      end
    end
    if (done_hit) begin
      result_d = bus.unit_result;
      err_d    = 1'b0;
    end else if (timeout_hit) begin
      result_d = '0;
      err_d    = 1'b1;
    end
  end

  always_comb begin
    bus.req_ready  = reset && (state_q == StIdle);
    bus.unit_start = start_q;
    bus.unit_a     = a_q;
    bus.unit_b     = b_q;
    bus.rsp_valid  = (state_q == StResp);
    bus.rsp_result = result_q;
    bus.rsp_err    = err_q;
  end

endmodule
